// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage pipelined floating-point adder/subtractor.
//   S1: special-case detect, operand swap, alignment with guard/round/sticky
//   S2: signed mantissa add/subtract
//   S3: leading-zero normalise, round-to-nearest-even, pack
// Subnormal inputs are flushed to zero; subnormal outputs are never produced.
// Optional feature macro: FPADD_EXC_FLAGS_EN -- when defined, exception flags
// {invalid, overflow, underflow, inexact} are computed and registered with the
// result; otherwise flags is tied to zero.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);
  localparam int XW     = MAN_W + 4;        // hidden, fraction, G, R, S
  localparam int AW     = MAN_W + 3;        // hidden, fraction, G, R
  localparam int SW     = MAN_W + 5;        // sum with carry bit
  localparam int EW2    = EXP_W + 8;        // wide exponent, room for negative values
  localparam int LZW    = $clog2(XW);
  localparam int SH_MAX = MAN_W + 3;
  localparam logic [EXP_W-1:0] EONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic         w_adv;
  logic [3:1]   r_vld_pipe;

  assign w_adv     = out_ready | ~r_vld_pipe[3];
  assign in_ready  = w_adv;
  assign out_valid = r_vld_pipe[3];

  // ---------------- S1: decode, special cases, swap, align ----------------
  logic [EXP_W-1:0] w_ea, w_eb, w_e_big, w_e_sml;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_za, w_zb, w_ia, w_ib, w_na, w_nb;
  logic             w_sb_eff, w_a_ge_b, w_s_big, w_s_sml;
  logic [MAN_W:0]   w_m_big, w_m_sml;
  logic [31:0]      w_diff, w_sh;
  logic [2*AW-1:0]  w_wide;
  logic [XW-1:0]    w_mb_ext, w_ms_ext;
  logic             w_spc;
  logic [W-1:0]     w_spc_val;

  assign w_ea     = a[W-2 -: EXP_W];
  assign w_eb     = b[W-2 -: EXP_W];
  assign w_za     = (w_ea == '0);
  assign w_zb     = (w_eb == '0);
  assign w_fa     = w_za ? '0 : a[MAN_W-1:0];
  assign w_fb     = w_zb ? '0 : b[MAN_W-1:0];
  assign w_ia     = (w_ea == EONES) && (a[MAN_W-1:0] == '0);
  assign w_ib     = (w_eb == EONES) && (b[MAN_W-1:0] == '0);
  assign w_na     = (w_ea == EONES) && (a[MAN_W-1:0] != '0);
  assign w_nb     = (w_eb == EONES) && (b[MAN_W-1:0] != '0);
  assign w_sb_eff = b[W-1] ^ op;
  assign w_a_ge_b = {w_ea, w_fa} >= {w_eb, w_fb};

  // Larger magnitude becomes the alignment base
  always_comb begin
    w_e_big = w_a_ge_b ? w_ea : w_eb;
    w_e_sml = w_a_ge_b ? w_eb : w_ea;
    w_s_big = w_a_ge_b ? a[W-1] : w_sb_eff;
    w_s_sml = w_a_ge_b ? w_sb_eff : a[W-1];
    w_m_big = w_a_ge_b ? {~w_za, w_fa} : {~w_zb, w_fb};
    w_m_sml = w_a_ge_b ? {~w_zb, w_fb} : {~w_za, w_fa};
  end

  // Shift into a double-width field; everything landing in the low half is sticky
  assign w_diff   = 32'(w_e_big - w_e_sml);
  assign w_sh     = (w_diff > 32'(SH_MAX)) ? 32'(SH_MAX) : w_diff;
  assign w_wide   = {w_m_sml, 2'b00, {AW{1'b0}}} >> w_sh;
  assign w_ms_ext = {w_wide[2*AW-1:AW], |w_wide[AW-1:0]};
  assign w_mb_ext = {w_m_big, 3'b000};

  // NaN / infinity results bypass the arithmetic path
  always_comb begin
    w_spc     = 1'b0;
    w_spc_val = '0;
    if (w_na || w_nb) begin
      w_spc     = 1'b1;
      w_spc_val = QNAN;
    end else if (w_ia && w_ib) begin
      w_spc     = 1'b1;
      w_spc_val = (a[W-1] != w_sb_eff) ? QNAN : {a[W-1], EONES, {MAN_W{1'b0}}};
    end else if (w_ia) begin
      w_spc     = 1'b1;
      w_spc_val = {a[W-1], EONES, {MAN_W{1'b0}}};
    end else if (w_ib) begin
      w_spc     = 1'b1;
      w_spc_val = {w_sb_eff, EONES, {MAN_W{1'b0}}};
    end
  end

`ifdef FPADD_EXC_FLAGS_EN
  logic w_inv;
  assign w_inv = w_ia & w_ib & (a[W-1] ^ w_sb_eff);
  logic r1_inv, r2_inv;
`endif

  logic             r1_sb, r1_ss, r1_spc, r1_zsign;
  logic [EXP_W-1:0] r1_e;
  logic [XW-1:0]    r1_mb, r1_ms;
  logic [W-1:0]     r1_spc_val;

  // S1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_sb <= 1'b0; r1_ss <= 1'b0; r1_spc <= 1'b0; r1_zsign <= 1'b0;
      r1_e <= '0; r1_mb <= '0; r1_ms <= '0; r1_spc_val <= '0;
`ifdef FPADD_EXC_FLAGS_EN
      r1_inv <= 1'b0;
`endif
    end else if (w_adv) begin
      r1_sb      <= w_s_big;
      r1_ss      <= w_s_sml;
      r1_spc     <= w_spc;
      r1_zsign   <= a[W-1] & w_sb_eff;   // only (-0)+(-0) keeps a negative zero
      r1_e       <= w_e_big;
      r1_mb      <= w_mb_ext;
      r1_ms      <= w_ms_ext;
      r1_spc_val <= w_spc_val;
`ifdef FPADD_EXC_FLAGS_EN
      r1_inv     <= w_inv;
`endif
    end
  end

  // ---------------- S2: mantissa add/subtract ----------------
  logic [SW-1:0]    w_sum;
  logic             r2_sign, r2_spc, r2_zsign;
  logic [EXP_W-1:0] r2_e;
  logic [SW-1:0]    r2_sum;
  logic [W-1:0]     r2_spc_val;

  // Base magnitude is never smaller, so the difference cannot go negative
  assign w_sum = (r1_sb ^ r1_ss) ? ({1'b0, r1_mb} - {1'b0, r1_ms})
                                 : ({1'b0, r1_mb} + {1'b0, r1_ms});

  // S2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_sign <= 1'b0; r2_spc <= 1'b0; r2_zsign <= 1'b0;
      r2_e <= '0; r2_sum <= '0; r2_spc_val <= '0;
`ifdef FPADD_EXC_FLAGS_EN
      r2_inv <= 1'b0;
`endif
    end else if (w_adv) begin
      r2_sign    <= r1_sb;
      r2_spc     <= r1_spc;
      r2_zsign   <= r1_zsign;
      r2_e       <= r1_e;
      r2_sum     <= w_sum;
      r2_spc_val <= r1_spc_val;
`ifdef FPADD_EXC_FLAGS_EN
      r2_inv     <= r1_inv;
`endif
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [LZW-1:0]   w_lz;
  logic [XW-1:0]    w_norm;
  logic [EW2-1:0]   w_en, w_er;
  logic [MAN_W+1:0] w_mr;
  logic [MAN_W-1:0] w_frac;
  logic             w_udf, w_ovf, w_zero, w_rup, w_inx;
  logic [W-1:0]     w_res;

  // Leading-zero count below the carry bit: highest set bit wins
  always_comb begin
    w_lz = '0;
    for (int i = 0; i < XW; i++)
      if (r2_sum[i]) w_lz = LZW'(XW - 1 - i);
  end

  assign w_norm = r2_sum[SW-1] ? {r2_sum[SW-1:2], |r2_sum[1:0]}
                               : (r2_sum[XW-1:0] << w_lz);
  assign w_en   = r2_sum[SW-1] ? EW2'(r2_e) + EW2'(1) : EW2'(r2_e) - EW2'(w_lz);
  assign w_udf  = w_en[EW2-1] | (w_en == '0);
  assign w_rup  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_mr   = {1'b0, w_norm[XW-1:3]} + (MAN_W+2)'(w_rup);
  assign w_er   = w_en + EW2'(w_mr[MAN_W+1]);
  assign w_frac = w_mr[MAN_W+1] ? w_mr[MAN_W:1] : w_mr[MAN_W-1:0];
  assign w_ovf  = ~w_udf & (w_er >= EW2'(EONES));
  assign w_zero = (r2_sum == '0);
  assign w_inx  = |w_norm[2:0];

  // Result selection, specials first
  always_comb begin
    w_res = {r2_sign, w_er[EXP_W-1:0], w_frac};
    if (r2_spc)      w_res = r2_spc_val;
    else if (w_zero) w_res = {r2_zsign, {(W-1){1'b0}}};
    else if (w_udf)  w_res = {r2_sign, {(W-1){1'b0}}};
    else if (w_ovf)  w_res = {r2_sign, EONES, {MAN_W{1'b0}}};
  end

`ifdef FPADD_EXC_FLAGS_EN
  logic [3:0] w_flg, r_flags;

  // Flag selection mirrors the result priority
  always_comb begin
    w_flg = {3'b000, w_inx};
    if (r2_spc)      w_flg = {r2_inv, 3'b000};
    else if (w_zero) w_flg = 4'b0000;
    else if (w_udf)  w_flg = 4'b0011;
    else if (w_ovf)  w_flg = 4'b0101;
  end

  // Flag register, advances with the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_flags <= 4'b0000;
    else if (w_adv) r_flags <= w_flg;
  end
  assign flags = r_flags;
`else
  assign flags = 4'b0000;
`endif

  logic [W-1:0] r_result;

  // S3 register and valid shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_vld_pipe <= '0;
    end else if (w_adv) begin
      r_result   <= w_res;
      r_vld_pipe <= {r_vld_pipe[2:1], in_valid};
    end
  end
  assign result = r_result;

endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width (range 4..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (range 4..52); the word width is W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts the operands this cycle.
REQ-007 SHALL have port a  input  W  operand A {sign, exp, frac}.
REQ-008 SHALL have port b  input  W  operand B.
REQ-009 SHALL have port op  input  1  0 = A+B, 1 = A-B (B's sign is inverted at accept).
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port result  output  W  rounded sum.
REQ-013 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact} for the current result.

Function
REQ-014 SHALL implement 3 registered stages: S1 special-case detect, swap and align with guard/round/sticky; S2 signed mantissa add/subtract; S3 leading-zero normalise, round and pack.
REQ-015 SHALL use global enable adv = out_ready | ~out_valid; in_ready = adv; all stages, including bubbles, advance only when adv=1.
REQ-016 SHALL accept an operand pair when in_valid & in_ready, and present its result 3 cycles later if adv stays 1; results leave in acceptance order.
REQ-017 SHALL hold result, flags and out_valid stable while out_valid & ~out_ready.
REQ-018 SHALL treat exp==0 inputs as zero of the same sign (flush-to-zero); it SHALL never produce subnormal outputs.
REQ-019 SHALL give the larger-magnitude operand as the alignment base; the shift amount saturates at MAN_W+3, with all shifted-out bits ORed into sticky.
REQ-020 SHALL round to nearest, ties to even, using guard/round/sticky; a carry out of rounding increments the exponent.
REQ-021 SHALL return canonical quiet NaN {0, all-ones, 1 followed by zeros} for any NaN input, and for inf-inf with opposite effective signs; the latter SHALL set invalid.
REQ-022 SHALL return the signed infinity when exactly one operand is inf, or both are inf with the same effective sign.
REQ-023 SHALL return +0 for an exact zero sum of opposite signs, and -0 for (-0)+(-0).
REQ-024 SHALL, when the rounded exponent is at least all-ones, return signed infinity with overflow=1 and inexact=1.
REQ-025 SHALL, when the normalised exponent is at most 0, return a signed zero with underflow=1 and inexact=1.
REQ-026 SHALL set inexact whenever any of guard, round or sticky is nonzero.

Reset
REQ-027 SHALL, on rst_n low, clear all stage valid bits, out_valid, result and flags to 0 immediately, independent of clk.
REQ-028 SHALL discard in-flight operations on reset mid-operation; no stale result SHALL appear after release.
REQ-029 SHALL drive in_ready=1 during and after reset, because out_valid=0.

Configuration
REQ-030 SHALL, with FPADD_EXC_FLAGS_EN defined, compute and register flags alongside result, per REQ-021..026.
REQ-031 SHALL, without FPADD_EXC_FLAGS_EN, drive flags constant 4'b0000 with no flag logic; result values, including special cases, SHALL be unchanged.

Verification (EXP_W=8, MAN_W=23, FPADD_EXC_FLAGS_EN defined, out_ready=1 unless stated)
REQ-032 SHALL cover a=0x3F800000, b=0x40000000, op=0 -> result 0x40400000, flags 0, out_valid exactly 3 cycles after accept.
REQ-033 SHALL cover a=0x3F800000 with b=0x33800000 -> 0x3F800000 (tie to even), and with b=0x34400000 -> 0x3F800002; both inexact=1.
REQ-034 SHALL cover a=0x7F800000, b=0x7F800000, op=1 -> 0x7FC00000, flags 4'b1000; and a=b=0x3F800000, op=1 -> 0x00000000, flags 0.
REQ-035 SHALL cover a=b=0x7F7FFFFF, op=0 -> 0x7F800000, flags 4'b0101; and a=0x00800000, b=0x80800001 -> 0x80000000, flags 4'b0011.
REQ-036 SHALL cover backpressure: 5 back-to-back inputs with out_ready low for 6 cycles -> in_ready low while the pipeline is stalled, and all 5 results delivered in order with none lost or duplicated.
REQ-037 SHALL cover reset: rst_n pulsed low with 2 operations in flight -> out_valid=0 immediately, and no output until a new accept plus 3 cycles.
